// File: rtl/fetch_stage_pipelined_if.sv
// Fetch-stage bus: decode-side control/targets, instruction-memory port and IF/ID outputs.
// The fetch stage uses the master view; decode and memory use the slave view.
interface fetch_stage_pipelined_if #(
  parameter int PC_W = 32,
  parameter int AW   = 8
);
  logic            stall_fp;
  logic            flush_fp;
  logic            branch_taken_fp;
  logic [31:0]     branch_offset_fp;
  logic            jump_fp;
  logic [25:0]     jump_addr_fp;
  logic [AW-1:0]   imem_addr_fp;
  logic [31:0]     imem_data_fp;
  logic [PC_W-1:0] pc_fp;
  logic [31:0]     instr_id_fp;
  logic [PC_W-1:0] pc4_id_fp;
  logic            valid_id_fp;
  logic            halted_fp;
  logic [31:0]     fetch_count_fp;

  modport master (
    input  stall_fp, flush_fp, branch_taken_fp, branch_offset_fp,
           jump_fp, jump_addr_fp, imem_data_fp,
    output imem_addr_fp, pc_fp, instr_id_fp, pc4_id_fp,
           valid_id_fp, halted_fp, fetch_count_fp
  );

  modport slave (
    output stall_fp, flush_fp, branch_taken_fp, branch_offset_fp,
           jump_fp, jump_addr_fp, imem_data_fp,
    input  imem_addr_fp, pc_fp, instr_id_fp, pc4_id_fp,
           valid_id_fp, halted_fp, fetch_count_fp
  );
endinterface

// File: rtl/fetch_stage_pipelined.sv
// Instruction-fetch stage: PC register, instruction-memory addressing and the IF/ID register,
// with stall, flush, one-bubble redirect, halt detection and a fetched-instruction counter.
module fetch_stage_pipelined #(
  parameter int              PC_W       = 32,
  parameter int              IMEM_DEPTH = 256,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [31:0]     HALT_WORD  = 32'hFC00_0000
) (
  input  logic                      clk_fp,
  input  logic                      rst_fp,
  fetch_stage_pipelined_if.master   bus
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_id_q, instr_id_d;
  logic [PC_W-1:0] pc4_id_q, pc4_id_d;
  logic            valid_id_q, valid_id_d;
  logic            halted_q, halted_d;
  logic [31:0]     count_q, count_d;

  logic [PC_W-1:0]  pc_plus4;
  logic [PC_W-1:0]  br_tgt;
  logic [PC_W-1:0]  jmp_tgt;
  logic [PC_W+31:0] off_ext;
  logic             unused_off_bits;
  logic             load_valid;
  logic             halt_hit;

  // Targets come from the instruction sitting in ID, so they are based on pc4_id_q.
  assign off_ext         = {{PC_W{bus.branch_offset_fp[31]}}, bus.branch_offset_fp};
  assign br_tgt          = pc4_id_q + {off_ext[PC_W-3:0], 2'b00};
  assign unused_off_bits = ^off_ext[PC_W+31:PC_W-2];

  generate
    if (PC_W > 28) begin : g_jmp_wide
      assign jmp_tgt = {pc4_id_q[PC_W-1:28], bus.jump_addr_fp, 2'b00};
    end else begin : g_jmp_narrow
      assign jmp_tgt = {bus.jump_addr_fp, 2'b00};
    end
  endgenerate

  assign pc_plus4   = pc_q + PC_W'(4);
  assign load_valid = !bus.flush_fp && !bus.stall_fp && !halted_q &&
                      !bus.jump_fp && !bus.branch_taken_fp;
  assign halt_hit   = load_valid && (bus.imem_data_fp == HALT_WORD);

  always_comb begin
    pc_d       = pc_q;
    instr_id_d = instr_id_q;
    pc4_id_d   = pc4_id_q;
    valid_id_d = valid_id_q;
    halted_d   = halted_q | halt_hit;
    count_d    = count_q + {31'd0, load_valid};

    // Loading the halt word freezes the PC at the halt address on the same edge.
    if (halted_q || bus.stall_fp || halt_hit) begin
      pc_d = pc_q;
    end else if (bus.jump_fp) begin
      pc_d = jmp_tgt;
    end else if (bus.branch_taken_fp) begin
      pc_d = br_tgt;
    end else begin
      pc_d = pc_plus4;
    end

    if (bus.flush_fp) begin
      instr_id_d = '0;
      pc4_id_d   = '0;
      valid_id_d = 1'b0;
    end else if (bus.stall_fp) begin
      instr_id_d = instr_id_q;
      pc4_id_d   = pc4_id_q;
      valid_id_d = valid_id_q;
    end else if (load_valid) begin
      instr_id_d = bus.imem_data_fp;
      pc4_id_d   = pc_plus4;
      valid_id_d = 1'b1;
    end else begin
      instr_id_d = '0;
      pc4_id_d   = '0;
      valid_id_d = 1'b0;
    end
  end

  always_ff @(posedge clk_fp) begin
    if (rst_fp) begin
      pc_q       <= RESET_PC;
      instr_id_q <= '0;
      pc4_id_q   <= '0;
      valid_id_q <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_id_q <= instr_id_d;
      pc4_id_q   <= pc4_id_d;
      valid_id_q <= valid_id_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
    end
  end

  assign bus.imem_addr_fp   = pc_q[AW+1:2];
  assign bus.pc_fp          = pc_q;
  assign bus.instr_id_fp    = instr_id_q;
  assign bus.pc4_id_fp      = pc4_id_q;
  assign bus.valid_id_fp    = valid_id_q;
  assign bus.halted_fp      = halted_q;
  assign bus.fetch_count_fp = count_q;
endmodule

// File: doc/fetch_stage_pipelined.md
# fetch_stage_pipelined

Parametrised instruction-fetch stage for the pipelined MIPS datapath. It owns the PC register, drives the instruction-memory address, and holds the IF/ID pipeline register. It supports stall, flush, branch/jump redirect with a one-cycle squash, halt detection, and a fetched-instruction counter. It replaces the single-cycle fetch loop and sits between instruction memory and the decode stage.

## Interface
- PC_W, 32, PC and target width (≥ 28)
- IMEM_DEPTH, 256, instruction memory depth in words (power of two)
- RESET_PC, 0, PC value loaded on reset (word aligned)
- HALT_WORD, 32'hFC00_0000, instruction encoding that stops fetch
- Reset is synchronous and active-high; one clock.
- clk_fp  in  1  clock, all state updates on rising edge
- rst_fp  in  1  synchronous active-high reset
- stall_fp  in  1  hold PC and IF/ID
- flush_fp  in  1  replace IF/ID contents with a bubble
- branch_taken_fp  in  1  branch in ID resolved taken
- branch_offset_fp  in  32  sign-extended immediate of the branch in ID
- jump_fp  in  1  jump in ID
- jump_addr_fp  in  26  jump target field of the jump in ID
- imem_addr_fp  out  log2(IMEM_DEPTH)  word address = pc_fp[log2(IMEM_DEPTH)+1:2]
- imem_data_fp  in  32  asynchronous-read instruction word
- pc_fp  out  PC_W  current fetch PC
- instr_id_fp  out  32  IF/ID instruction
- pc4_id_fp  out  PC_W  IF/ID PC+4
- valid_id_fp  out  1  IF/ID holds a real instruction
- halted_fp  out  1  fetch stopped on HALT_WORD
- fetch_count_fp  out  32  number of valid instructions written to IF/ID

## Operation
- The decode-stage targets are computed from pc4_id_fp, not pc_fp.
  - Branch target = pc4_id_fp + (branch_offset_fp << 2), truncated to PC_W.
  - Jump target = {pc4_id_fp[PC_W-1:28], jump_addr_fp, 2'b00}.
- Next-PC priority, highest first: rst_fp → RESET_PC; halted_fp → hold; stall_fp → hold; jump_fp → jump target; branch_taken_fp → branch target; otherwise pc_fp+4.
- IF/ID update priority: rst_fp → zeros, valid 0; flush_fp → bubble (instr 0, pc4 0, valid 0); stall_fp → hold; halted_fp → bubble; jump_fp or branch_taken_fp → bubble, because the word fetched this cycle is squashed; otherwise load instr=imem_data_fp, pc4=pc_fp+4, valid=1.
- Flush and stall together: IF/ID takes the bubble and the PC holds.
- Jump and branch together: jump wins.
- Redirects are ignored while stall_fp=1. Decode keeps them asserted because ID holds.
- Halt: when imem_data_fp==HALT_WORD and IF/ID loads it as valid, halted_fp is set on the same edge.
  - The PC freezes at the halt address.
  - Later IF/ID loads are bubbles.
  - Only rst_fp clears the halt.
- A HALT_WORD squashed by a redirect, stall or flush does not halt.
- fetch_count_fp increments by 1 on every edge where IF/ID loads with valid=1, including the halt word. It wraps 2^32−1 → 0.
- PC wrap: PC_W-bit arithmetic wraps modulo 2^PC_W. imem_addr_fp wraps modulo IMEM_DEPTH.

## Timing
- Reset values: pc_fp=RESET_PC, instr_id_fp=0, pc4_id_fp=0, valid_id_fp=0, halted_fp=0, fetch_count_fp=0.
- imem_addr_fp is combinational from pc_fp. Memory read is same-cycle.
- Latency is 1 cycle PC→ID. The first valid_id_fp=1 appears after the first edge with rst_fp=0.
- Redirect penalty is exactly one bubble: the target instruction is in ID two edges after the redirect cycle.
- Reset asserted mid-stall, mid-halt or with a redirect pending: all state returns to reset values on that edge and all inputs that cycle are ignored.

## Test plan
- **Sequential fetch.** Reset, memory word i = i+1, run 4 cycles.
  - ID sees instr 1,2,3,4 with pc4 4,8,12,16, valid=1.
  - fetch_count_fp=4.
- **Branch.** ID instr at pc4=8, branch_taken_fp=1, offset=3.
  - Next pc_fp=20; IF/ID bubble for one cycle.
  - Then instr word 5 with pc4=24.
- **Jump plus branch.** jump_fp=1, jump_addr_fp=26'h10, branch_taken_fp=1 same cycle.
  - pc_fp=0x40 (jump wins); one bubble.
- **Stall and flush.** stall_fp=1 for 3 cycles with a branch asserted: pc_fp and IF/ID constant, count unchanged. Then stall_fp=flush_fp=1: valid_id_fp=0 and pc_fp held.
- **Halt.** HALT_WORD at address 12.
  - After it loads: halted_fp=1, pc_fp=12 frozen, valid_id_fp=0 afterwards, count stops at 4.
  - Apply rst_fp: all outputs return to reset values.
- **Wrap.** IMEM_DEPTH=4, run 6 cycles: imem_addr_fp sequence 0,1,2,3,0,1.
